// File: rtl/stopwatch_tick_counter_if.sv
// Control and display bundle between the stopwatch tick counter and its surroundings.
// The master drives commands and the divided tick wave; the slave returns the time and status.
interface stopwatch_tick_counter_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic       running;
  logic       tick_pulse;
  logic       overflow;
  logic       tick_lost;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  sec_lo, sec_hi, min_lo, min_hi, running, tick_pulse, overflow, tick_lost
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output sec_lo, sec_hi, min_lo, min_hi, running, tick_pulse, overflow, tick_lost
  );
endinterface

// File: rtl/stopwatch_tick_counter.sv
// Synchronises the 1 Hz divider wave, counts BCD MM:SS under start/stop/clear and flags a dead
// tick source. Defining STOPWATCH_LAP_HOLD_EN adds a lap-hold freeze of the digit outputs.
module stopwatch_tick_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 12000000,
  parameter int TO_W        = 24
) (
  input logic                     Clk,
  input logic                     rst_n,
  stopwatch_tick_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   tick_pulse_q, tick_pulse_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   running_q, running_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   tick_lost_q, tick_lost_d;
  logic [16:0]            inc_s;
  logic [15:0]            disp_s;

  // {wrap, next} for one second added to {min_hi, min_lo, sec_hi, sec_lo}.
  function automatic logic [16:0] mmss_inc(input logic [15:0] t);
    logic [15:0] n;
    logic        wrap;
    n    = t;
    wrap = 1'b0;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
            wrap     = 1'b1;
          end
        end
      end
    end
    return {wrap, n};
  endfunction

  // Tick edge detect, command FSM and time counter; clear beats start_stop beats tick.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    hist_d       = sync_q[SYNC_STAGES-1];
    tick_pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    overflow_d   = 1'b0;
    inc_s        = mmss_inc(cnt_q);
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = 16'h0000;
    end else if (bus.start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (tick_pulse_q && (state_q == RUN)) begin
      cnt_d      = inc_s[15:0];
      overflow_d = inc_s[16];
    end else begin
      cnt_d = cnt_q;
    end
    running_d = (state_d == RUN);
  end

  // Liveness watchdog: saturating cycle count since the last tick, sticky alarm at the limit.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    tick_lost_d = tick_lost_q;
    if (bus.clear || tick_pulse_q) begin
      to_cnt_d    = {TO_W{1'b0}};
      tick_lost_d = 1'b0;
    end else begin
      if (to_cnt_q == TO_MAX) begin
        to_cnt_d = to_cnt_q;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
      tick_lost_d = tick_lost_q | (to_cnt_d == TO_MAX);
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= {SYNC_STAGES{1'b0}};
      hist_q       <= 1'b0;
      tick_pulse_q <= 1'b0;
      cnt_q        <= 16'h0000;
      overflow_q   <= 1'b0;
      running_q    <= 1'b0;
      to_cnt_q     <= {TO_W{1'b0}};
      tick_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hist_q       <= hist_d;
      tick_pulse_q <= tick_pulse_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      running_q    <= running_d;
      to_cnt_q     <= to_cnt_d;
      tick_lost_q  <= tick_lost_d;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] disp_q, disp_d;

  // Lap-hold: freeze the shown time in RUN until a second lap, start_stop or clear.
  always_comb begin
    hold_d = hold_q;
    if (bus.clear || bus.start_stop) begin
      hold_d = 1'b0;
    end else if (bus.lap && hold_q) begin
      hold_d = 1'b0;
    end else if (bus.lap && (state_q == RUN)) begin
      hold_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
    disp_d = hold_d ? disp_q : cnt_d;
  end

  // Display registers for the lap-hold view.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      disp_q <= 16'h0000;
    end else begin
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign disp_s = disp_q;
`else
  logic lap_unused_s;
  assign lap_unused_s = bus.lap;
  assign disp_s       = cnt_q;
`endif

  assign bus.sec_lo     = disp_s[3:0];
  assign bus.sec_hi     = disp_s[7:4];
  assign bus.min_lo     = disp_s[11:8];
  assign bus.min_hi     = disp_s[15:12];
  assign bus.running    = running_q;
  assign bus.tick_pulse = tick_pulse_q;
  assign bus.overflow   = overflow_q;
  assign bus.tick_lost  = tick_lost_q;
endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Scoreboard bench for stopwatch_tick_counter: each generated tick pushes the expected
// {digits, overflow, running}; a monitor pops and compares once the digits have updated.
module tb_stopwatch_tick_counter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_tick_counter_if sw_if ();

  stopwatch_tick_counter #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(100),
    .TO_W       (8)
  ) dut (
    .Clk  (clk),
    .rst_n(rst_n),
    .bus  (sw_if.slave)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [17:0] exp_q[$];
  logic        prev_pulse = 1'b0;
  int          m_state = 0;  // 0 idle, 1 run, 2 pause
  int          m_time  = 0;  // seconds
  int          m_disp  = 0;
  logic        m_hold  = 1'b0;

  wire [15:0] dut_time = {sw_if.min_hi, sw_if.min_lo, sw_if.sec_hi, sw_if.sec_lo};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_tick();
    logic ovf;
    ovf = 1'b0;
    if (m_state == 1) begin
      ovf    = (m_time == 3599);
      m_time = (m_time + 1) % 3600;
    end
    if (!m_hold) m_disp = m_time;
    exp_q.push_back({to_bcd(m_disp), ovf, (m_state == 1)});
  endtask

  task automatic send_tick();
    model_tick();
    sw_if.tick_in = 1'b1;
    repeat (4) step();
    sw_if.tick_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_cmd(input logic ss, input logic clr, input logic lp);
    sw_if.start_stop = ss;
    sw_if.clear      = clr;
    sw_if.lap        = lp;
    if (clr) begin
      m_state = 0; m_time = 0; m_hold = 1'b0;
    end else if (ss) begin
      m_state = (m_state == 1) ? 2 : 1;
      m_hold  = 1'b0;
    end else if (lp) begin
`ifdef STOPWATCH_LAP_HOLD_EN
      if (m_hold) m_hold = 1'b0;
      else if (m_state == 1) m_hold = 1'b1;
`endif
    end
    if (!m_hold) m_disp = m_time;
    step();
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
  endtask

  // Scoreboard monitor: digits settle one cycle after each tick pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse <= 1'b0;
    end else begin
      if (prev_pulse) begin
        chk("pulse_width", sw_if.tick_pulse, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          chk("sb_digits", dut_time, exp_q[0][17:2]);
          chk("sb_overflow", sw_if.overflow, exp_q[0][1]);
          chk("sb_running", sw_if.running, exp_q[0][0]);
          void'(exp_q.pop_front());
        end
      end else if (sw_if.overflow) begin
        chk("overflow_stray", 1, 0);
      end
      prev_pulse <= sw_if.tick_pulse;
    end
  end

  initial begin
    sw_if.tick_in = 1'b0; sw_if.start_stop = 1'b0; sw_if.clear = 1'b0; sw_if.lap = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle with tick_in low.
    repeat (50) step();
    chk("rst_digits", dut_time, 16'h0000);
    chk("rst_running", sw_if.running, 0);
    chk("rst_pulse", sw_if.tick_pulse, 0);
    chk("rst_overflow", sw_if.overflow, 0);
    chk("rst_lost", sw_if.tick_lost, 0);

    // Pulse latency: raised after edge N, high only after edge N+3.
    model_tick();
    sw_if.tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("latency_e%0d", k), sw_if.tick_pulse, (k == 3) ? 1 : 0);
    end
    sw_if.tick_in = 1'b0;
    repeat (4) step();
    chk("idle_digits", dut_time, 16'h0000);
    chk("idle_running", sw_if.running, 0);

    // Run 75 s, then pause and confirm ticks are ignored.
    pulse_cmd(1'b1, 1'b0, 1'b0);
    chk("run_running", sw_if.running, 1);
    repeat (75) send_tick();
    chk("count_0115", dut_time, 16'h0115);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    chk("pause_running", sw_if.running, 0);
    repeat (5) send_tick();
    chk("pause_0115", dut_time, 16'h0115);

    // Wrap 59:59 -> 00:00.
    pulse_cmd(1'b0, 1'b1, 1'b0);
    chk("clear_digits", dut_time, 16'h0000);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    repeat (3598) send_tick();
    chk("preload_5958", dut_time, 16'h5958);
    repeat (2) send_tick();
    chk("wrap_digits", dut_time, 16'h0000);
    chk("wrap_running", sw_if.running, 1);
    chk("wrap_overflow_done", sw_if.overflow, 0);

    // clear + start_stop on the same edge as a tick pulse.
    pulse_cmd(1'b0, 1'b1, 1'b0);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    repeat (7) send_tick();
    chk("pre_coinc_0007", dut_time, 16'h0007);
    sw_if.tick_in = 1'b1;
    repeat (3) step();
    chk("coinc_pulse_up", sw_if.tick_pulse, 1);
    sw_if.clear = 1'b1; sw_if.start_stop = 1'b1;
    m_state = 0; m_time = 0; m_hold = 1'b0; m_disp = 0;
    exp_q.push_back({16'h0000, 1'b0, 1'b0});
    step();
    sw_if.clear = 1'b0; sw_if.start_stop = 1'b0;
    chk("coinc_digits", dut_time, 16'h0000);
    chk("coinc_running", sw_if.running, 0);
    sw_if.tick_in = 1'b0;
    repeat (4) step();

    // Lap pulse: freezes the view only when lap-hold is built in.
    pulse_cmd(1'b1, 1'b0, 1'b0);
    repeat (3) send_tick();
    pulse_cmd(1'b0, 1'b0, 1'b1);
    repeat (4) send_tick();
`ifdef STOPWATCH_LAP_HOLD_EN
    chk("lap_view", dut_time, 16'h0003);
`else
    chk("lap_view", dut_time, 16'h0007);
`endif
    pulse_cmd(1'b0, 1'b0, 1'b1);
    chk("lap_release", dut_time, 16'h0007);

    // Asynchronous reset mid-count.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", dut_time, 16'h0000);
    chk("async_rst_running", sw_if.running, 0);
    m_state = 0; m_time = 0; m_hold = 1'b0; m_disp = 0;
    repeat (2) step();
    rst_n = 1'b1;

    // Watchdog: alarm on edge 99 after reset, cleared by a tick, then by clear.
    for (int c = 1; c <= 99; c++) begin
      step();
      if (c == 98) chk("lost_e98", sw_if.tick_lost, 0);
      if (c == 99) chk("lost_e99", sw_if.tick_lost, 1);
    end
    model_tick();
    sw_if.tick_in = 1'b1;
    repeat (3) step();
    chk("lost_at_pulse", sw_if.tick_lost, 1);
    step();
    chk("lost_tick_clr", sw_if.tick_lost, 0);
    sw_if.tick_in = 1'b0;
    repeat (110) step();
    chk("lost_again", sw_if.tick_lost, 1);
    pulse_cmd(1'b0, 1'b1, 1'b0);
    chk("lost_clear_clr", sw_if.tick_lost, 0);

    repeat (5) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
